// File: rtl/mul_sched_if.sv
// Request/response, randomness and multiplier-side signal bundle for mul_sched.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface mul_sched_if #(
    parameter int d     = 1,
    parameter int N_REQ = 4
);
    localparam int W  = 8 + d;
    localparam int RW = (9 + d) * d;

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0][W-1:0]  req_p1;
    logic [N_REQ-1:0][W-1:0]  req_p2;
    logic [N_REQ-1:0]         rsp_valid;
    logic [N_REQ-1:0]         rsp_ready;
    logic [W-1:0]             rsp_data;
    logic                     rsp_err;
    logic                     rnd_valid;
    logic                     rnd_ready;
    logic [RW-1:0]            rnd_data;
    logic                     mul_drdy_i;
    logic [W-1:0]             mul_p1;
    logic [W-1:0]             mul_p2;
    logic [RW-1:0]            mul_rnd;
    logic                     mul_drdy_o;
    logic [W-1:0]             mul_out;

    modport slave (
        input  req_valid, req_p1, req_p2, rsp_ready, rnd_valid, rnd_data,
               mul_drdy_o, mul_out,
        output req_ready, rsp_valid, rsp_data, rsp_err, rnd_ready,
               mul_drdy_i, mul_p1, mul_p2, mul_rnd
    );

    modport master (
        output req_valid, req_p1, req_p2, rsp_ready, rnd_valid, rnd_data,
               mul_drdy_o, mul_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err, rnd_ready,
               mul_drdy_i, mul_p1, mul_p2, mul_rnd
    );
endinterface

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one serial masked multiplier between N_REQ requesters.
// Fetches fresh randomness per operation and holds it stable for the whole computation.
//
//   state   | meaning
//   S_IDLE  | arbitrate from ptr, accept one request
//   S_FETCH | wait for a randomness vector
//   S_ISSUE | one-cycle start pulse with operands on the multiplier
//   S_WAIT  | wait for mul_drdy_o or abort on timeout
//   S_RESP  | present result to the granted requester until accepted
module mul_sched #(
    parameter int d       = 1,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 16 + 2 * d
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_sched_if.slave bus,
    output logic       busy,
    output logic       err_timeout
);
    localparam int W  = 8 + d;
    localparam int RW = (9 + d) * d;
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } fsm_state_t;

    fsm_state_t    state;
    fsm_state_t    state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    logic [IW-1:0] g;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;
    logic          grant_ok;
    logic          run_q;
    logic [W-1:0]  op_p1;
    logic [W-1:0]  op_p2;
    logic [RW-1:0] rnd_q;
    logic [W-1:0]  res_q;
    logic          err_q;
    logic [CW-1:0] wait_cnt;

    // run_q keeps req_ready low while reset is asserted even though IDLE is combinational
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (bus.req_valid[cand]) begin
                grant_ok  = run_q;
                grant_idx = cand;
            end
        end
    end

    assign ptr_nxt = (g == IW'(N_REQ - 1)) ? '0 : g + 1'b1;
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = '0;
        bus.rnd_ready  = 1'b0;
        bus.mul_drdy_i = 1'b0;
        bus.mul_p1     = '0;
        bus.mul_p2     = '0;
        bus.mul_rnd    = '0;
        bus.rsp_valid  = '0;
        bus.rsp_data   = '0;
        bus.rsp_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_ok) begin
                    bus.req_ready[grant_idx] = 1'b1;
                    state_nxt                = S_FETCH;
                end
            end
            S_FETCH: begin
                bus.rnd_ready = 1'b1;
                if (bus.rnd_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                bus.mul_drdy_i = 1'b1;
                bus.mul_p1     = op_p1;
                bus.mul_p2     = op_p2;
                bus.mul_rnd    = rnd_q;
                state_nxt      = S_WAIT;
            end
            S_WAIT: begin
                bus.mul_rnd = rnd_q;
                if (bus.mul_drdy_o || wait_cnt == '0) state_nxt = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid[g] = 1'b1;
                bus.rsp_data     = res_q;
                bus.rsp_err      = err_q;
                if (bus.rsp_ready[g]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // wait_cnt counts down from TIMEOUT-1; reaching zero without done means TIMEOUT WAIT cycles elapsed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            run_q       <= 1'b0;
            ptr         <= '0;
            g           <= '0;
            op_p1       <= '0;
            op_p2       <= '0;
            rnd_q       <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        g     <= grant_idx;
                        op_p1 <= bus.req_p1[grant_idx];
                        op_p2 <= bus.req_p2[grant_idx];
                    end
                end
                S_FETCH: begin
                    if (bus.rnd_valid) rnd_q <= bus.rnd_data;
                end
                S_ISSUE: begin
                    op_p1    <= '0;
                    op_p2    <= '0;
                    wait_cnt <= CW'(TIMEOUT - 1);
                end
                S_WAIT: begin
                    if (bus.mul_drdy_o) begin
                        res_q <= bus.mul_out;
                        err_q <= 1'b0;
                        rnd_q <= '0;
                    end else if (wait_cnt == '0) begin
                        res_q       <= '0;
                        err_q       <= 1'b1;
                        err_timeout <= 1'b1;
                        rnd_q       <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready[g]) begin
                        res_q <= '0;
                        err_q <= 1'b0;
                        ptr   <= ptr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_sched.sv
// Scoreboard bench for mul_sched: randomized requests, a stub multiplier and a cyclic-priority reference.
// Expected responses are queued at randomness fetch and popped by an independent response monitor.
`timescale 1ns/1ps
module tb_mul_sched;
    localparam int D   = 1;
    localparam int N   = 4;
    localparam int T   = 16 + 2 * D;
    localparam int W   = 8 + D;
    localparam int RW  = (9 + D) * D;
    localparam int LAT = 9 + D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err_timeout;

    mul_sched_if #(.d(D), .N_REQ(N)) bus ();

    mul_sched #(.d(D), .N_REQ(N), .TIMEOUT(T)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        logic         err;
        int           rsp_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    int checks = 0, failures = 0, cyc = 0, grants = 0, rsp_count = 0, hyg_viol = 0;
    int model_ptr = 0, grant_seq = 0, drv_seq = 0, last_grant_idx = 0, last_grant_cyc = 0;
    int rnd_stall = 0, left = 0, cur_idx = 0, cur_rsp_idx = 0, g_exp = 0;
    logic chk_interval = 0, int_valid = 0, keep_valid = 0, stub_dead = 0, in_fetch = 0;
    logic rsp_seen = 0, in_op = 0, prev_hold = 0, prev_e = 0;
    logic [N-1:0]  prev_v = '0;
    logic [W-1:0]  prev_d = '0;
    logic [W-1:0]  cur_p1 = '0, cur_p2 = '0;
    logic [RW-1:0] cur_rnd = '0, op_rnd = '0;
    logic [W-1:0]  stub_p1, stub_p2;
    int            stub_k;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    // stub multiplier result: GF(2^8) product masked by the low randomness byte, top share bits folded
    function automatic logic [W-1:0] stub_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [RW-1:0] r);
        return {a[W-1:8] ^ b[W-1:8] ^ r[RW-1 -: D], gf_mul(a[7:0], b[7:0]) ^ r[7:0]};
    endfunction

    function automatic int pick(input int p, input logic [N-1:0] m);
        for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic expire(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // multiplier model: done rises LAT cycles after the start pulse, unless stubbed dead
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mul_drdy_o <= 1'b0;
            bus.mul_out    <= '0;
            stub_k         <= 0;
        end else if (bus.mul_drdy_i) begin
            stub_k         <= 1;
            bus.mul_drdy_o <= 1'b0;
            stub_p1        <= bus.mul_p1;
            stub_p2        <= bus.mul_p2;
        end else if (stub_k != 0) begin
            if (stub_k == LAT) begin
                stub_k <= 0;
                if (!stub_dead) begin
                    bus.mul_drdy_o <= 1'b1;
                    bus.mul_out    <= stub_fn(stub_p1, stub_p2, bus.mul_rnd);
                end
            end else begin
                stub_k <= stub_k + 1;
            end
        end
    end

    initial begin
        bus.rnd_valid = 1'b1;
        bus.rnd_data  = RW'($urandom);
        forever begin
            @(posedge clk);
            #2;
            if (bus.rnd_ready) begin
                if (!in_fetch) begin
                    in_fetch = 1'b1;
                    left     = rnd_stall;
                end else if (left > 0) begin
                    left--;
                end
                bus.rnd_valid = (left == 0);
            end else begin
                in_fetch      = 1'b0;
                bus.rnd_valid = (rnd_stall == 0);
                bus.rnd_data  = RW'($urandom);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (drv_seq != grant_seq) begin
            drv_seq = grant_seq;
            if (keep_valid) begin
                bus.req_p1[last_grant_idx] = W'($urandom);
                bus.req_p2[last_grant_idx] = W'($urandom);
            end
        end
    end

    // grant / fetch / issue monitor: checks arbitration and pushes the expected response
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            int_valid = 1'b0;
        end else begin
            if (bus.req_ready != '0) begin
                g_exp = pick(model_ptr, bus.req_valid);
                check("grant_onehot", bus.req_ready, (g_exp < 0) ? '0 : ({{(N-1){1'b0}}, 1'b1} << g_exp));
                if (chk_interval && int_valid) check("grant_interval", cyc - last_grant_cyc, 14 + D);
                int_valid      = chk_interval;
                cur_idx        = (g_exp < 0) ? 0 : g_exp;
                cur_p1         = bus.req_p1[cur_idx];
                cur_p2         = bus.req_p2[cur_idx];
                last_grant_cyc = cyc;
                last_grant_idx = cur_idx;
                grants++;
                grant_seq++;
            end
            if (bus.rnd_ready && bus.rnd_valid) begin
                check("fetch_delay", cyc - last_grant_cyc, 1 + rnd_stall);
                cur_rnd = bus.rnd_data;
                sb_q.push_back('{idx: cur_idx,
                                 data: stub_dead ? '0 : stub_fn(cur_p1, cur_p2, bus.rnd_data),
                                 err: stub_dead,
                                 rsp_cyc: cyc + (stub_dead ? 2 + T : 12 + D)});
            end
            if (bus.mul_drdy_i) begin
                check("issue_latency", cyc - last_grant_cyc, 2 + rnd_stall);
                check("issue_operands", {bus.mul_p1, bus.mul_p2}, {cur_p1, cur_p2});
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sb_q.delete();
            model_ptr = 0;
            rsp_seen  = 1'b0;
        end else if (bus.rsp_valid != '0) begin
            if (!rsp_seen) begin
                rsp_seen = 1'b1;
                if (sb_q.size() == 0) begin
                    expire("unexpected_rsp");
                end else begin
                    e = sb_q.pop_front();
                    cur_rsp_idx = e.idx;
                    check("rsp_index", bus.rsp_valid, {{(N-1){1'b0}}, 1'b1} << e.idx);
                    check("rsp_data", bus.rsp_data, e.data);
                    check("rsp_err", bus.rsp_err, e.err);
                    check("rsp_latency", cyc, e.rsp_cyc);
                end
            end
            if ((bus.rsp_valid & bus.rsp_ready) != '0) begin
                rsp_seen  = 1'b0;
                model_ptr = (cur_rsp_idx + 1) % N;
                rsp_count++;
            end
        end
    end

    // per-cycle masking hygiene and hold-stability rules, tallied into one final comparison
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            in_op     = 1'b0;
            prev_hold = 1'b0;
        end else begin
            if (!bus.mul_drdy_i && (bus.mul_p1 != '0 || bus.mul_p2 != '0)) begin
                hyg_viol++; $display("hygiene: operands outside issue at cycle %0d", cyc);
            end
            if ((!busy || bus.rsp_valid != '0) && bus.mul_rnd != '0) begin
                hyg_viol++; $display("hygiene: randomness leak at cycle %0d", cyc);
            end
            if (bus.rsp_valid == '0 && (bus.rsp_data != '0 || bus.rsp_err)) begin
                hyg_viol++; $display("hygiene: rsp bus not idle at cycle %0d", cyc);
            end
            if (bus.req_ready != '0 && (busy || !$onehot(bus.req_ready) ||
                                        (bus.req_ready & ~bus.req_valid) != '0)) begin
                hyg_viol++; $display("hygiene: bad req_ready at cycle %0d", cyc);
            end
            if (!$onehot0(bus.rsp_valid)) begin
                hyg_viol++; $display("hygiene: rsp_valid not one-hot at cycle %0d", cyc);
            end
            if (bus.mul_drdy_i) begin
                in_op  = 1'b1;
                op_rnd = bus.mul_rnd;
                if (op_rnd != cur_rnd) begin
                    hyg_viol++; $display("hygiene: issue randomness differs at cycle %0d", cyc);
                end
            end else if (bus.rsp_valid != '0) begin
                in_op = 1'b0;
            end else if (in_op && bus.mul_rnd != op_rnd) begin
                hyg_viol++; $display("hygiene: randomness moved in wait at cycle %0d", cyc);
            end
            if (prev_hold && (bus.rsp_valid != prev_v || bus.rsp_data != prev_d || bus.rsp_err != prev_e)) begin
                hyg_viol++; $display("hygiene: response changed while held at cycle %0d", cyc);
            end
            prev_hold = (bus.rsp_valid != '0) && ((bus.rsp_valid & bus.rsp_ready) == '0);
            prev_v    = bus.rsp_valid;
            prev_d    = bus.rsp_data;
            prev_e    = bus.rsp_err;
        end
    end

    task automatic wait_grants(input int target);
        int n = 0;
        while (grants < target && n < 300) begin
            @(negedge clk); #1; n++;
        end
        if (grants < target) expire("grant_wait");
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk); #1;
        while (busy && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (busy) expire("idle_wait");
    endtask

    task automatic do_op(input logic [N-1:0] mask);
        int g0;
        for (int i = 0; i < N; i++) begin
            bus.req_p1[i] = W'($urandom);
            bus.req_p2[i] = W'($urandom);
        end
        @(posedge clk); #2;
        bus.req_valid = mask;
        g0 = grants;
        wait_grants(g0 + 1);
        @(posedge clk); #2;
        bus.req_valid = '0;
        wait_idle();
    endtask

    function automatic logic [63:0] all_outputs();
        return {busy, err_timeout, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err,
                bus.rnd_ready, bus.mul_drdy_i, bus.mul_p1, bus.mul_p2, bus.mul_rnd};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, rc0, n;
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            bus.req_p1[i] = '0;
            bus.req_p2[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_outputs", all_outputs(), '0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // all requesters continuously: 0,1,2,3,0 at 14+D spacing
        chk_interval = 1'b1;
        keep_valid   = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.req_p1[i] = W'($urandom);
            bus.req_p2[i] = W'($urandom);
        end
        bus.req_valid = '1;
        g0 = grants;
        wait_grants(g0 + 5);
        keep_valid = 1'b0;
        @(posedge clk); #2;
        bus.req_valid = '0;
        wait_idle();
        chk_interval = 1'b0;

        // directed single operation from requester 1
        @(posedge clk); #2;
        bus.req_p1[1] = 9'h0A3;
        bus.req_p2[1] = 9'h15C;
        bus.req_valid = 4'b0010;
        g0 = grants;
        wait_grants(g0 + 1);
        @(posedge clk); #2;
        bus.req_valid = '0;
        wait_idle();

        rnd_stall = 5;
        do_op(4'b0100);
        for (int k = 0; k < 10; k++) begin
            rnd_stall = $urandom_range(0, 3);
            do_op(N'($urandom_range(1, (1 << N) - 1)));
        end
        rnd_stall = 0;

        check("err_timeout_before_abort", err_timeout, 1'b0);
        stub_dead = 1'b1;
        do_op(4'b0001);
        stub_dead = 1'b0;
        check("err_timeout_sticky", err_timeout, 1'b1);
        do_op(4'b1010);
        check("err_timeout_after_good_op", err_timeout, 1'b1);

        // response held 10 cycles; requester 0 waits; rsp_ready on other indices is ignored
        bus.rsp_ready = 4'b0111;
        @(posedge clk); #2;
        bus.req_p1[3] = W'($urandom);
        bus.req_p2[3] = W'($urandom);
        bus.req_valid = 4'b1000;
        g0 = grants;
        wait_grants(g0 + 1);
        @(posedge clk); #2;
        bus.req_valid = 4'b0001;
        n = 0;
        while (bus.rsp_valid == '0 && n < 60) begin
            @(negedge clk); #1; n++;
        end
        if (bus.rsp_valid == '0) expire("rsp_wait");
        g0 = grants;
        repeat (10) begin
            @(negedge clk); #1;
        end
        check("no_grant_while_held", grants, g0);
        check("rsp_still_valid", bus.rsp_valid, 4'b1000);
        @(posedge clk); #2;
        bus.rsp_ready = '1;
        wait_grants(g0 + 1);
        @(posedge clk); #2;
        bus.req_valid = '0;
        wait_idle();

        // reset during WAIT: served requester 1 leaves ptr at 2, reset must bring it back to 0
        do_op(4'b0010);
        @(posedge clk); #2;
        bus.req_valid = 4'b1000;
        g0 = grants;
        wait_grants(g0 + 1);
        @(posedge clk); #2;
        bus.req_valid = '0;
        n = 0;
        while (!bus.mul_drdy_i && n < 40) begin
            @(negedge clk); #1; n++;
        end
        if (!bus.mul_drdy_i) expire("issue_wait");
        repeat (3) begin
            @(negedge clk); #1;
        end
        rst_n         = 1'b0;
        bus.req_valid = 4'b0110;
        rc0           = rsp_count;
        @(negedge clk); #1;
        check("reset_midop_outputs", all_outputs(), '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        g0 = grants;
        wait_grants(g0 + 1);
        @(posedge clk); #2;
        bus.req_valid = '0;
        wait_idle();
        check("one_rsp_after_reset", rsp_count, rc0 + 1);

        repeat (3) @(negedge clk);
        check("hygiene_violations", hyg_viol, 0);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
